// File: rtl/clk_enable_pkg.sv
// Shared types and constants for the clock-enable bank.
// Mode encoding and the channel-index width helper live here so the top and the channel agree.
package clk_enable_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } ch_mode_e;

  localparam int MAX_CH = 16;

  // A single channel still gets a 1-bit select field.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// One enable channel: divide-by-(D+1) counter with periodic/one-shot modes,
// a double-buffered divisor and a restart input shared across the bank.
module clk_enable_chan
  import clk_enable_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   en_i,
  input  logic                   mode_i,
  input  logic                   sync_i,
  input  logic                   wr_i,
  input  logic [COUNT_WIDTH-1:0] wr_div_i,
  output logic                   clk_en_o,
  output logic                   done_o
);

  logic [COUNT_WIDTH-1:0] div_q, div_d;
  logic [COUNT_WIDTH-1:0] pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   done_q, done_d;

  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    done_d     = done_q;

    if (!en_i) begin
      // Idle: re-arm, and a write takes effect immediately.
      cnt_d  = '0;
      done_d = 1'b0;
      if (wr_i) begin
        div_d      = wr_div_i;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (done_q) begin
        cnt_d = '0;
      end else if (sync_i) begin
        cnt_d = '0;
        if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else if (cnt_q >= div_q) begin
        // >= so a divisor lowered under the count still wraps next edge.
        cnt_d   = '0;
        pulse_d = 1'b1;
        done_d  = (ch_mode_e'(mode_i) == MODE_ONESHOT);
        if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end

      // Placed last so a write coinciding with a wrap/sync lands in the next period.
      if (wr_i) begin
        pend_d     = wr_div_i;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_q      <= COUNT_WIDTH'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
  end

  assign clk_en_o = pulse_q;
  assign done_o   = done_q;

endmodule

// File: rtl/clk_enable_bank.sv
// Bank of N_CH independent clock-enable channels sharing one divisor write port
// and one sync restart input.
module clk_enable_bank
  import clk_enable_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [N_CH-1:0]             ch_en,
  input  logic [N_CH-1:0]             ch_mode,
  input  logic                        sync_in,
  input  logic                        wr_en,
  input  logic [ch_idx_w(N_CH)-1:0]   wr_ch,
  input  logic [COUNT_WIDTH-1:0]      wr_div,
  output logic [N_CH-1:0]             clk_en,
  output logic [N_CH-1:0]             done
);

  localparam int WCH = ch_idx_w(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_sel;
    // Out-of-range indices match no instance, so they drop silently.
    assign wr_sel = wr_en && (wr_ch == WCH'(i));

    clk_enable_chan #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .en_i     (ch_en[i]),
      .mode_i   (ch_mode[i]),
      .sync_i   (sync_in),
      .wr_i     (wr_sel),
      .wr_div_i (wr_div),
      .clk_en_o (clk_en[i]),
      .done_o   (done[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_bank.sv
// Directed bench for clk_enable_bank; five channels so an out-of-range write index is expressible.
module tb_clk_enable_bank;

  localparam int N_CH = 5;
  localparam int CW   = 8;
  localparam int WCH  = 3;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [N_CH-1:0] ch_en, ch_mode;
  logic            sync_in, wr_en;
  logic [WCH-1:0]  wr_ch;
  logic [CW-1:0]   wr_div;
  logic [N_CH-1:0] clk_en, done;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_enable_bank #(
    .N_CH        (N_CH),
    .COUNT_WIDTH (CW),
    .DEFAULT_DIV (1)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .ch_en    (ch_en),
    .ch_mode  (ch_mode),
    .sync_in  (sync_in),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .clk_en   (clk_en),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_idle(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = WCH'(ch);
    wr_div = CW'(d);
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    ch_en = '0; ch_mode = '0; sync_in = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    tick();
    tick();
    checks++;
    if (clk_en !== '0) begin errors++; $display("FAIL reset clk_en: got %b want 00000", clk_en); end
    checks++;
    if (done !== '0) begin errors++; $display("FAIL reset done: got %b want 00000", done); end
    reset_in = 1'b0;
  endtask

  // Default divisor 1: pulse every second edge, none on the first edge after reset.
  task automatic test_periodic();
    logic exp;
    ch_en[0] = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e % 2 == 1);
      checks++;
      if (clk_en[0] !== exp) begin errors++; $display("FAIL periodic e%0d: clk_en[0]=%b want %b", e, clk_en[0], exp); end
    end
    ch_en[0] = 1'b0;
    tick();
  endtask

  // D=2 running; two writes mid-period (last wins), applied at the next wrap.
  task automatic test_pending_write();
    logic exp;
    write_idle(1, 2);
    ch_en[1] = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      wr_en = 1'b0;
      if (e == 3) begin wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd9; end
      if (e == 4) begin wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd4; end
      tick();
      exp = (e == 2 || e == 5 || e == 10);
      checks++;
      if (clk_en[1] !== exp) begin errors++; $display("FAIL pending e%0d: clk_en[1]=%b want %b", e, clk_en[1], exp); end
    end
    wr_en = 1'b0;
    ch_en[1] = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    logic exp;
    write_idle(2, 3);
    ch_mode[2] = 1'b1;
    ch_en[2]   = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e == 3);
      checks++;
      if (clk_en[2] !== exp) begin errors++; $display("FAIL oneshot e%0d: clk_en[2]=%b want %b", e, clk_en[2], exp); end
      exp = (e >= 3);
      checks++;
      if (done[2] !== exp) begin errors++; $display("FAIL oneshot_done e%0d: done[2]=%b want %b", e, done[2], exp); end
    end
    ch_en[2] = 1'b0;
    tick();
    checks++;
    if (done[2] !== 1'b0) begin errors++; $display("FAIL oneshot_rearm: done[2]=%b want 0", done[2]); end
    ch_en[2] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      exp = (e == 3);
      checks++;
      if (clk_en[2] !== exp) begin errors++; $display("FAIL oneshot_again e%0d: clk_en[2]=%b want %b", e, clk_en[2], exp); end
    end
    checks++;
    if (done[2] !== 1'b1) begin errors++; $display("FAIL oneshot_again_done: done[2]=%b want 1", done[2]); end
    ch_en[2] = 1'b0;
    ch_mode[2] = 1'b0;
    tick();
  endtask

  // Sync lands on ch0's wrap edge: no pulse there, both restart aligned.
  task automatic test_sync();
    logic exp;
    write_idle(0, 2);
    write_idle(3, 5);
    ch_en[0] = 1'b1;
    ch_en[3] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      sync_in = (e == 2);
      tick();
      exp = (e == 5 || e == 8);
      checks++;
      if (clk_en[0] !== exp) begin errors++; $display("FAIL sync ch0 e%0d: clk_en[0]=%b want %b", e, clk_en[0], exp); end
      exp = (e == 8);
      checks++;
      if (clk_en[3] !== exp) begin errors++; $display("FAIL sync ch3 e%0d: clk_en[3]=%b want %b", e, clk_en[3], exp); end
    end
    sync_in = 1'b0;
    ch_en = '0;
    tick();
  endtask

  // Out-of-range writes are dropped; D=0 holds the enable high.
  task automatic test_bad_write_d0();
    logic exp;
    write_idle(5, 7);
    write_idle(7, 7);
    ch_en[0] = 1'b1;
    ch_en[1] = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e == 2 || e == 5);
      checks++;
      if (clk_en[0] !== exp) begin errors++; $display("FAIL badwr ch0 e%0d: clk_en[0]=%b want %b", e, clk_en[0], exp); end
      exp = (e == 4);
      checks++;
      if (clk_en[1] !== exp) begin errors++; $display("FAIL badwr ch1 e%0d: clk_en[1]=%b want %b", e, clk_en[1], exp); end
    end
    ch_en = '0;
    tick();
    write_idle(1, 0);
    ch_en[1] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (clk_en[1] !== 1'b1) begin errors++; $display("FAIL d0 e%0d: clk_en[1]=%b want 1", e, clk_en[1]); end
    end
    ch_en = '0;
    tick();
  endtask

  // Reset mid-period with a pending write and a coincident write.
  task automatic test_reset_mid();
    logic exp;
    ch_en[0] = 1'b1;
    ch_en[3] = 1'b1;
    tick();
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd6;
    tick();
    wr_ch = 3'd3; wr_div = 8'd9;
    reset_in = 1'b1;
    tick();
    checks++;
    if (clk_en !== '0) begin errors++; $display("FAIL rstmid clk_en: got %b want 00000", clk_en); end
    checks++;
    if (done !== '0) begin errors++; $display("FAIL rstmid done: got %b want 00000", done); end
    reset_in = 1'b0;
    wr_en = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e % 2 == 1);
      checks++;
      if (clk_en[0] !== exp) begin errors++; $display("FAIL rstmid ch0 e%0d: clk_en[0]=%b want %b", e, clk_en[0], exp); end
      checks++;
      if (clk_en[3] !== exp) begin errors++; $display("FAIL rstmid ch3 e%0d: clk_en[3]=%b want %b", e, clk_en[3], exp); end
    end
    ch_en = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_pending_write();
    test_oneshot();
    test_sync();
    test_bad_write_d0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_enable_bank.md
CLK_ENABLE_BANK -- requirements
Module: clk_enable_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent enable channels (1..16).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of each channel's divisor and counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 1: divisor loaded into every channel at reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
  clk_in  input  1  clock; all state updates on its rising edge
  reset_in  input  1  synchronous active-high reset
REQ-005 SHALL have the remaining ports:
  ch_en  input  N_CH  per-channel run enable, sampled every edge
  ch_mode  input  N_CH  per-channel mode: 0 = periodic, 1 = one-shot
  sync_in  input  1  restart all running counters together
  wr_en  input  1  divisor write strobe
  wr_ch  input  $clog2(N_CH) (min 1)  target channel of the write
  wr_div  input  COUNT_WIDTH  divisor value to write
  clk_en  output  N_CH  registered single-cycle enable pulse per channel
  done  output  N_CH  registered; one-shot channel has fired and is waiting for re-arm

Function
REQ-006 Each channel SHALL hold an active divisor D, a pending divisor, a pending-valid flag, a counter cnt and a done flag.
REQ-007 If ch_en[i]=0, each edge SHALL set cnt=0, clk_en[i]=0 and done[i]=0.
REQ-008 If ch_en[i]=1 and done[i]=0, then on an edge with cnt==D: cnt<=0 and clk_en[i]<=1. Otherwise: cnt<=cnt+1 and clk_en[i]<=0.
REQ-009 Periodic timing SHALL work as follows. If ch_en[i] rises with cnt=0 at edge k, clk_en[i] is high for one cycle after edges k+D, k+2D+1, and so on, giving a period of D+1 cycles.
REQ-010 With D=0, clk_en[i] SHALL stay high continuously while the channel runs.
REQ-011 In one-shot mode (ch_mode[i]=1), the edge that produces the pulse SHALL also set done[i]=1.
REQ-012 While done[i]=1, the channel SHALL hold cnt=0 and clk_en[i]=0. It re-arms only when ch_en[i] is deasserted (REQ-007).
REQ-013 ch_mode[i] SHALL be sampled only at the wrap edge. Changing it mid-count does not disturb the count.
REQ-014 A write (wr_en=1, wr_ch<N_CH) to a channel with ch_en=0 SHALL load D immediately.
REQ-015 A write to a running channel SHALL store the value as pending and set pending-valid. D takes the pending value at the next wrap edge or the next sync_in edge, and pending-valid clears.
REQ-016 Multiple writes to one channel before it applies SHALL resolve last-write-wins.
REQ-017 A write with wr_ch>=N_CH SHALL be ignored.
REQ-018 A write on the same edge as a wrap SHALL become pending for the following period. The wrap uses the old D.
REQ-019 sync_in=1 SHALL act on every channel with ch_en=1 and done=0: cnt<=0, clk_en<=0, pending divisor applied. It has priority over a coincident wrap, so no pulse is emitted on that edge.
REQ-020 sync_in SHALL NOT affect idle channels or done channels.
REQ-021 The counter SHALL never exceed D. If D is lowered below cnt by an immediate load, the channel wraps on the next edge.
REQ-022 All arithmetic SHALL be unsigned COUNT_WIDTH, with no overflow possible per REQ-021.

Reset
REQ-023 reset_in=1 SHALL set every channel to: D=DEFAULT_DIV, pending-valid=0, cnt=0, clk_en=0, done=0.
REQ-024 reset_in SHALL override all other inputs on that edge, including a mid-period or mid-write edge.
REQ-025 No output SHALL pulse on the first edge after reset_in deasserts.

Structure
REQ-026 Package clk_enable_pkg SHALL hold the mode typedef (MODE_PERIODIC=0, MODE_ONESHOT=1) and the N_CH bound constant.
REQ-027 One sub-module, clk_enable_chan, SHALL implement a single channel (REQ-006..022). clk_enable_bank generates N_CH instances plus write decode.

Verification
REQ-028 Reset; ch_en[0]=1, D=1 -> clk_en[0] pulses every 2nd cycle, first pulse after edge 1.
REQ-029 Write D=4 to running ch1 mid-period (cnt=2, old D=2) -> next pulse after old period (3 cycles); subsequent period 5 cycles.
REQ-030 ch2 one-shot, D=3 -> exactly one pulse after edge 3, done[2]=1 thereafter; drop ch_en 1 cycle -> done clears, next pulse 4 cycles after re-enable.
REQ-031 ch0 D=2 and ch3 D=5 running; sync_in on edge where ch0 cnt==2 -> no ch0 pulse on that edge; both channels restart from cnt=0 aligned.
REQ-032 wr_ch=N_CH with wr_div=7 -> no channel divisor changes; D=0 on ch1 -> clk_en[1] constantly high.
REQ-033 Assert reset_in mid-period with pending write -> all outputs 0 next cycle; pending discarded; D=DEFAULT_DIV.
